// File: rtl/clm_pkg.sv
// Shared defaults and FSM state encoding for the signed product-term accumulator.
package clm_pkg;

    localparam int ACC_W_DEF = 16;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_CORR = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/clm_sign_acc_if.sv
// Term-input and sum-output handshake bundle for clm_sign_acc.
// out_ovf exists only when CLM_ACC_OVF_EN is defined.
interface clm_sign_acc_if #(
    parameter int ACC_W = clm_pkg::ACC_W_DEF,
    parameter int CNT_W = clm_pkg::CNT_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [6:0]       in_result;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_terms;
`ifdef CLM_ACC_OVF_EN
    logic             out_ovf;

    modport master (
        output in_valid, in_sign, in_result, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_terms, out_ovf
    );
    modport slave (
        input  in_valid, in_sign, in_result, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_terms, out_ovf
    );
`else
    modport master (
        output in_valid, in_sign, in_result, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_terms
    );
    modport slave (
        input  in_valid, in_sign, in_result, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_terms
    );
`endif
endinterface

// File: rtl/clm_acc_add.sv
// W-bit two's-complement adder with signed-overflow flag; result wraps modulo 2^W.
module clm_acc_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);
    assign sum = a + b;
    // Overflow when both operands share a sign that the result does not.
    assign ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
endmodule

// File: rtl/clm_sign_acc.sv
// Accumulates one's-complement products, then adds the negative-term count once per frame
// to convert to an exact two's-complement sum. CLM_ACC_OVF_EN adds a sticky out_ovf.
module clm_sign_acc
    import clm_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    clm_sign_acc_if.slave bus
);
    localparam logic [CNT_W-1:0] TERM_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] term_q, term_d;
    logic [CNT_W-1:0] neg_q, neg_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] add_b;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    // One adder serves both the per-term add and the end-of-frame correction.
    clm_acc_add #(.W(ACC_W)) u_add (
        .a   (acc_q),
        .b   (add_b),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        term_d      = term_q;
        neg_d       = neg_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        add_b       = '0;
        case (state_q)
            ST_ACC: begin
                add_b = ACC_W'($signed(bus.in_result));
                if (bus.in_valid && in_ready_q) begin
                    acc_d  = add_sum;
                    ovf_d  = ovf_q | add_ovf;
                    term_d = term_q + CNT_W'(1);
                    if (bus.in_sign) neg_d = neg_q + CNT_W'(1);
                    // A full term counter closes the frame even without in_last.
                    if (bus.in_last || (term_d == TERM_MAX)) begin
                        state_d    = ST_CORR;
                        in_ready_d = 1'b0;
                    end
                end
            end
            ST_CORR: begin
                add_b       = ACC_W'(neg_q);
                acc_d       = add_sum;
                ovf_d       = ovf_q | add_ovf;
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    acc_d       = '0;
                    term_d      = '0;
                    neg_d       = '0;
                    ovf_d       = 1'b0;
                    state_d     = ST_ACC;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_ACC;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            term_q      <= '0;
            neg_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            term_q      <= term_d;
            neg_q       <= neg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc_q;
    assign bus.out_terms = term_q;
`ifdef CLM_ACC_OVF_EN
    assign bus.out_ovf   = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: doc/clm_sign_acc.md
CLM_SIGN_ACC -- requirements
Module: clm_sign_acc

Interface
REQ-001 Parameter ACC_W, default 16: accumulator and output width in bits, two's complement, minimum 10.
REQ-002 Parameter CNT_W, default 8: width of the term and negative-term counters; a frame holds at most 2^CNT_W-1 terms.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: a product term is presented.
REQ-006 Port in_ready, output, 1: the block accepts a term this cycle.
REQ-007 Port in_sign, input, 1: product sign bit from the 4-bit sign-magnitude multiplier.
REQ-008 Port in_result, input, 7: one's-complement product from the multiplier (~{0,abs} when in_sign=1).
REQ-009 Port in_last, input, 1: the current term ends the frame.
REQ-010 Port out_valid, output, 1: the frame sum is available.
REQ-011 Port out_ready, input, 1: the downstream consumer takes the sum.
REQ-012 Port out_sum, output, ACC_W: exact signed sum of the frame.
REQ-013 Port out_terms, output, CNT_W: number of terms accepted in the frame.

Function
REQ-014 A term SHALL be accepted in a cycle where in_valid=1 and in_ready=1.
REQ-015 The FSM SHALL have three states: ACC (in_ready=1), CORR (in_ready=0) and DONE (in_ready=0, out_valid=1).
REQ-016 In ACC, each accepted term SHALL add in_result, sign-extended from bit 6 to ACC_W, to the accumulator.
REQ-017 In ACC, each accepted term SHALL increment the term counter, and SHALL increment the negative counter when in_sign=1.
REQ-018 The negative count SHALL be taken from in_sign; in_result[6] SHALL be used only for sign extension.
REQ-019 ACC SHALL go to CORR on an accepted term with in_last=1.
REQ-020 ACC SHALL also go to CORR when the accepted term makes the term counter equal 2^CNT_W-1, whatever the value of in_last.
REQ-021 CORR SHALL last exactly one cycle, add the zero-extended negative count to the accumulator, and go to DONE.
REQ-022 out_valid SHALL rise in the second cycle after the handshake cycle of the last term.
REQ-023 DONE SHALL hold out_sum and out_terms stable while out_ready=0.
REQ-024 On out_valid and out_ready both high, the block SHALL clear the accumulator and both counters and return to ACC in the next cycle.
REQ-025 Accumulator arithmetic SHALL wrap modulo 2^ACC_W.
REQ-026 A term with in_sign=1 and in_result=7'h7F (zero magnitude) SHALL contribute 0 to the final sum.
REQ-027 out_sum SHALL show the accumulator register at all times; it is defined only while out_valid=1.

Reset
REQ-028 While rst=1 on a clock edge, the block SHALL enter ACC and clear the accumulator and both counters.
REQ-029 After reset, outputs SHALL be in_ready=1, out_valid=0, out_sum=0, out_terms=0, and out_ovf=0 when present.
REQ-030 Reset SHALL take priority over any handshake in the same cycle.
REQ-031 Reset in mid-frame or in DONE SHALL discard the frame with no output.

Configuration
REQ-032 With macro CLM_ACC_OVF_EN defined, output port out_ovf (1 bit) SHALL exist.
REQ-033 out_ovf SHALL be a sticky flag, set when any signed addition in the frame (ACC or CORR) overflows ACC_W bits.
REQ-034 out_ovf SHALL be valid with out_valid and SHALL clear together with the accumulator.
REQ-035 Without CLM_ACC_OVF_EN, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-036 Package clm_pkg SHALL hold the default values of ACC_W and CNT_W and the FSM state enumeration.
REQ-037 Sub-module clm_acc_add SHALL perform the ACC_W-bit signed addition and report overflow; both the ACC and CORR additions SHALL use this one instance.

Verification
REQ-038 Bench: frame {(0,7'h06),(1,7'h79,last)} -> out_sum=16'h0000, out_terms=2, out_valid in the second cycle after the last handshake.
REQ-039 Bench: single term (1,7'h4E,last) -> out_sum=16'hFFCF (-49).
REQ-040 Bench: single term (1,7'h7F,last) -> out_sum=0.
REQ-041 Bench: out_ready held 0 for 5 cycles in DONE -> out_sum stable and in_ready=0; out_ready=1 -> next-cycle in_ready=1, and the next frame's sum excludes the old frame.
REQ-042 Bench: 255 terms of (0,7'h31) with in_last never set -> forced CORR, out_terms=255, out_sum=16'h30CF.
REQ-043 Bench: rst=1 after 3 accepted terms -> next frame of (0,7'h02,last) gives out_sum=2; with CLM_ACC_OVF_EN, ACC_W=10 and 12 terms of +49 -> out_ovf=1.
